// File: rtl/sobel_stream_pkg.sv
// Shared types and sizing helpers for the Sobel pixel-stream blocks.
// Default geometry matches the stored 512x512 frame.
package sobel_stream_pkg;

  localparam int PIX_W            = 8;
  localparam int DEF_IMAGE_WIDTH  = 512;
  localparam int DEF_IMAGE_HEIGHT = 512;
  localparam int DEF_PAD_ROWS     = 1;

  typedef logic [PIX_W-1:0] pix_t;

  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
  } stream_flags_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

  localparam int COL_W = cnt_width(DEF_IMAGE_WIDTH);
  localparam int ROW_W = cnt_width(DEF_IMAGE_HEIGHT + 2 * DEF_PAD_ROWS);

endpackage

// File: rtl/stream_skid_fifo.sv
// Two-entry data+flags FIFO; the head drives a valid/ready stream directly.
// Writes to a full FIFO and reads from an empty one are dropped.
module stream_skid_fifo
  import sobel_stream_pkg::*;
#(
  parameter int DATA_W = PIX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wr_en,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [2:0]        i_wr_flags,
  input  logic              i_rd_en,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_rd_data,
  output logic [2:0]        o_rd_flags,
  output logic [1:0]        o_count
);

  logic [DATA_W-1:0] r_data  [2];
  logic [2:0]        r_flags [2];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;
  logic              w_wr;
  logic              w_rd;

  always_comb begin
    w_wr = i_wr_en && (r_count != 2'd2);
    w_rd = i_rd_en && (r_count != 2'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        r_data[i]  <= '0;
        r_flags[i] <= '0;
      end
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_wr) begin
        r_data[r_wr_ptr]  <= i_wr_data;
        r_flags[r_wr_ptr] <= i_wr_flags;
        r_wr_ptr          <= ~r_wr_ptr;
      end
      if (w_rd) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    o_valid    = (r_count != 2'd0);
    o_rd_data  = r_data[r_rd_ptr];
    o_rd_flags = r_flags[r_rd_ptr];
    o_count    = r_count;
  end

endmodule

// File: rtl/image_stream_source.sv
// Raster pixel source: walks the stored frame plus optional zero padding rows and
// emits it as a valid/ready stream with sof/eol/eof tags.
module image_stream_source
  import sobel_stream_pkg::*;
#(
  parameter int IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
  parameter int IMAGE_HEIGHT = DEF_IMAGE_HEIGHT,
  parameter int PIXEL_WIDTH  = PIX_W,
  parameter int PAD_ROWS     = DEF_PAD_ROWS,
  parameter int ADDR_WIDTH   = 18
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   mem_rd_en,
  output logic [ADDR_WIDTH-1:0]  mem_rd_addr,
  input  logic [PIXEL_WIDTH-1:0] mem_rd_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [PIXEL_WIDTH-1:0] m_data,
  output logic                   m_sof,
  output logic                   m_eol,
  output logic                   m_eof
);

  localparam int VROWS = IMAGE_HEIGHT + 2 * PAD_ROWS;
  localparam int CW    = cnt_width(IMAGE_WIDTH);
  localparam int RW    = cnt_width(VROWS);

  localparam logic [CW-1:0] LAST_COL      = CW'(IMAGE_WIDTH - 1);
  localparam logic [RW-1:0] LAST_ROW      = RW'(VROWS - 1);
  localparam logic [RW-1:0] FIRST_IMG_ROW = RW'(PAD_ROWS);
  localparam logic [RW-1:0] FIRST_BOT_ROW = RW'(PAD_ROWS + IMAGE_HEIGHT);

  state_t                  r_state;
  state_t                  w_next_state;
  logic                    r_done;
  logic [RW-1:0]           r_row;
  logic [CW-1:0]           r_col;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_in_image;
  logic                    r_pend_valid;
  logic                    r_pend_pad;
  stream_flags_t           r_pend_flags;

  logic                    w_accept;
  logic                    w_pop;
  logic [1:0]              w_occupancy;
  logic                    w_credit;
  logic                    w_fetch;
  logic                    w_pad_row;
  logic [RW-1:0]           w_next_row;
  stream_flags_t           w_fetch_flags;
  stream_flags_t           w_head_flags;
  logic                    w_eof_pop;
  logic                    w_fifo_valid;
  logic [1:0]              w_fifo_count;
  logic [PIXEL_WIDTH-1:0]  w_fifo_wr_data;
  logic [PIXEL_WIDTH-1:0]  w_head_data;

  // A start coinciding with the done pulse is dropped so back-to-back frames need a fresh request.
  always_comb begin
    w_accept    = (r_state == IDLE) && start && !r_done;
    w_pop       = w_fifo_valid && m_ready;
    w_occupancy = 2'(r_pend_valid) + w_fifo_count - 2'(w_pop);
    w_credit    = (w_occupancy < 2'd2);
    w_fetch     = (r_state == RUN) && w_credit;
    w_pad_row   = !r_in_image;
    w_next_row  = r_row + 1'b1;

    w_fetch_flags.sof = (r_row == '0) && (r_col == '0);
    w_fetch_flags.eol = (r_col == LAST_COL);
    w_fetch_flags.eof = (r_row == LAST_ROW) && (r_col == LAST_COL);

    w_eof_pop = (r_state == DRAIN) && w_pop && w_head_flags.eof;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_next_state = RUN;
      RUN:     if (w_fetch && w_fetch_flags.eof) w_next_state = DRAIN;
      DRAIN:   if (w_eof_pop) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_done  <= w_eof_pop;
    end
  end

  // Raster walk over virtual rows; the address only advances on real image fetches.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_row      <= '0;
      r_col      <= '0;
      r_addr     <= '0;
      r_in_image <= 1'b0;
    end else if (w_accept) begin
      r_row      <= '0;
      r_col      <= '0;
      r_addr     <= '0;
      r_in_image <= (PAD_ROWS == 0);
    end else if (w_fetch) begin
      if (!w_pad_row) begin
        r_addr <= r_addr + 1'b1;
      end
      if (r_col == LAST_COL) begin
        r_col <= '0;
        r_row <= w_next_row;
        if (w_next_row == FIRST_BOT_ROW) begin
          r_in_image <= 1'b0;
        end else if (w_next_row == FIRST_IMG_ROW) begin
          r_in_image <= 1'b1;
        end
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // One-cycle slot matching the memory read latency; padding rides it with zero data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend_valid <= 1'b0;
      r_pend_pad   <= 1'b0;
      r_pend_flags <= '0;
    end else begin
      r_pend_valid <= w_fetch;
      r_pend_pad   <= w_pad_row;
      r_pend_flags <= w_fetch_flags;
    end
  end

  always_comb begin
    w_fifo_wr_data = r_pend_pad ? '0 : mem_rd_data;
  end

  stream_skid_fifo #(
    .DATA_W (PIXEL_WIDTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (reset_n),
    .i_wr_en    (r_pend_valid),
    .i_wr_data  (w_fifo_wr_data),
    .i_wr_flags (r_pend_flags),
    .i_rd_en    (w_pop),
    .o_valid    (w_fifo_valid),
    .o_rd_data  (w_head_data),
    .o_rd_flags (w_head_flags),
    .o_count    (w_fifo_count)
  );

  always_comb begin
    busy        = (r_state != IDLE);
    done        = r_done;
    mem_rd_en   = w_fetch && !w_pad_row;
    mem_rd_addr = r_addr;
    m_valid     = w_fifo_valid;
    m_data      = w_head_data;
    m_sof       = w_head_flags.sof;
    m_eol       = w_head_flags.eol;
    m_eof       = w_head_flags.eof;
  end

endmodule

// File: tb/tb_image_stream_source.sv
// Bench for image_stream_source: instance A is 4x3 with one padding row, instance B is
// 4x2 without padding; each has an address-valued memory model and a scoreboard monitor.
module tb_image_stream_source;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_vec = 0;
  int n_err = 0;

  // A: W=4 H=3 PAD=1
  logic       start_a, busy_a, done_a, mem_rd_en_a, m_valid_a, m_ready_a;
  logic       m_sof_a, m_eol_a, m_eof_a;
  logic [3:0] mem_rd_addr_a;
  logic [7:0] mem_rd_data_a, m_data_a;
  // B: W=4 H=2 PAD=0
  logic       start_b, busy_b, done_b, mem_rd_en_b, m_valid_b, m_ready_b;
  logic       m_sof_b, m_eol_b, m_eof_b;
  logic [2:0] mem_rd_addr_b;
  logic [7:0] mem_rd_data_b, m_data_b;

  image_stream_source #(.IMAGE_WIDTH(4), .IMAGE_HEIGHT(3), .PIXEL_WIDTH(8),
                        .PAD_ROWS(1), .ADDR_WIDTH(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .busy(busy_a), .done(done_a),
    .mem_rd_en(mem_rd_en_a), .mem_rd_addr(mem_rd_addr_a), .mem_rd_data(mem_rd_data_a),
    .m_valid(m_valid_a), .m_ready(m_ready_a), .m_data(m_data_a),
    .m_sof(m_sof_a), .m_eol(m_eol_a), .m_eof(m_eof_a)
  );

  image_stream_source #(.IMAGE_WIDTH(4), .IMAGE_HEIGHT(2), .PIXEL_WIDTH(8),
                        .PAD_ROWS(0), .ADDR_WIDTH(3)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .busy(busy_b), .done(done_b),
    .mem_rd_en(mem_rd_en_b), .mem_rd_addr(mem_rd_addr_b), .mem_rd_data(mem_rd_data_b),
    .m_valid(m_valid_b), .m_ready(m_ready_b), .m_data(m_data_b),
    .m_sof(m_sof_b), .m_eol(m_eol_b), .m_eof(m_eof_b)
  );

  // Memories hold their own address as pixel value, read latency 1.
  always @(posedge clk) begin
    if (mem_rd_en_a) mem_rd_data_a <= 8'(mem_rd_addr_a);
    if (mem_rd_en_b) mem_rd_data_b <= 8'(mem_rd_addr_b);
  end

  // Expected beat word: {from_mem, sof, eol, eof, data[7:0]}
  logic [11:0] exp_q_a[$];
  logic [11:0] exp_q_b[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_frame(input bit sel, input int w, input int h, input int pad);
    bit          is_pad;
    logic [7:0]  d;
    logic [11:0] e;
    for (int r = 0; r < h + 2 * pad; r++) begin
      for (int c = 0; c < w; c++) begin
        is_pad = (r < pad) || (r >= pad + h);
        d      = is_pad ? 8'd0 : 8'((r - pad) * w + c);
        e      = {!is_pad, (r == 0 && c == 0), (c == w - 1), (r == h + 2 * pad - 1 && c == w - 1), d};
        if (sel) exp_q_b.push_back(e);
        else     exp_q_a.push_back(e);
      end
    end
  endtask

  // ---------------- monitor A ----------------
  bit         prev_stall_a = 0, exp_done_a = 0;
  logic [10:0] prev_word_a;
  logic [10:0] act_a;
  logic [11:0] e_a;
  int         rd_tot_a = 0, mem_cons_a = 0, beats_a = 0, first_cyc_a = 0, last_cyc_a = 0;

  always @(negedge clk) begin
    act_a = {m_sof_a, m_eol_a, m_eof_a, m_data_a};
    if (!reset_n) begin
      prev_stall_a = 0; exp_done_a = 0; rd_tot_a = 0; mem_cons_a = 0;
    end else begin
      if (exp_done_a) begin
        check("a_done_pulse", 32'({done_a, busy_a}), 32'b10);
        exp_done_a = 0;
      end else if (done_a) begin
        n_vec++; n_err++;
        $display("FAIL a_done_spurious: got done=1 expected done=0 at cycle %0d", cyc);
      end
      if (prev_stall_a) check("a_stall_hold", 32'({m_valid_a, act_a}), 32'({1'b1, prev_word_a}));
      if (mem_rd_en_a) begin
        rd_tot_a++;
        check("a_addr_range", 32'(mem_rd_addr_a < 4'd12), 32'd1);
      end
      if (m_valid_a && m_ready_a) begin
        if (exp_q_a.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL a_extra_beat: got beat 0x%0h expected no beat", act_a);
        end else begin
          e_a = exp_q_a.pop_front();
          check("a_beat", 32'(act_a), 32'(e_a[10:0]));
          if (e_a[11]) mem_cons_a++;
          if (e_a[10]) first_cyc_a = cyc;
          if (e_a[8]) begin last_cyc_a = cyc; exp_done_a = 1; end
          beats_a++;
        end
      end
      if (mem_rd_en_a) check("a_read_ahead", 32'(rd_tot_a - mem_cons_a <= 2), 32'd1);
      prev_stall_a = m_valid_a && !m_ready_a;
      prev_word_a  = act_a;
    end
  end

  // ---------------- monitor B ----------------
  bit         prev_stall_b = 0, exp_done_b = 0;
  logic [10:0] prev_word_b;
  logic [10:0] act_b;
  logic [11:0] e_b;
  int         rd_tot_b = 0, mem_cons_b = 0, first_cyc_b = 0, last_cyc_b = 0, max_addr_b = 0;

  always @(negedge clk) begin
    act_b = {m_sof_b, m_eol_b, m_eof_b, m_data_b};
    if (!reset_n) begin
      prev_stall_b = 0; exp_done_b = 0; rd_tot_b = 0; mem_cons_b = 0;
    end else begin
      if (exp_done_b) begin
        check("b_done_pulse", 32'({done_b, busy_b}), 32'b10);
        exp_done_b = 0;
      end else if (done_b) begin
        n_vec++; n_err++;
        $display("FAIL b_done_spurious: got done=1 expected done=0 at cycle %0d", cyc);
      end
      if (prev_stall_b) check("b_stall_hold", 32'({m_valid_b, act_b}), 32'({1'b1, prev_word_b}));
      if (mem_rd_en_b) begin
        rd_tot_b++;
        if (int'(mem_rd_addr_b) > max_addr_b) max_addr_b = int'(mem_rd_addr_b);
      end
      if (m_valid_b && m_ready_b) begin
        if (exp_q_b.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL b_extra_beat: got beat 0x%0h expected no beat", act_b);
        end else begin
          e_b = exp_q_b.pop_front();
          check("b_beat", 32'(act_b), 32'(e_b[10:0]));
          if (e_b[11]) mem_cons_b++;
          if (e_b[10]) first_cyc_b = cyc;
          if (e_b[8]) begin last_cyc_b = cyc; exp_done_b = 1; end
        end
      end
      if (mem_rd_en_b) check("b_read_ahead", 32'(rd_tot_b - mem_cons_b <= 2), 32'd1);
      prev_stall_b = m_valid_b && !m_ready_b;
      prev_word_b  = act_b;
    end
  end

  // ---------------- drivers ----------------
  bit rand_a = 0;
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_a) m_ready_a = 1'($urandom_range(0, 1));
    end
  end

  task automatic pulse_start(input bit sel);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
  endtask

  task automatic wait_done(input bit sel, input int budget, input string name);
    for (int n = 0; n < budget; n++) begin
      @(posedge clk); #1;
      if ((sel ? done_b : done_a) === 1'b1) begin
        n_vec++;
        return;
      end
    end
    n_vec++; n_err++;
    $display("FAIL %s: got no done within %0d cycles expected done", name, budget);
  endtask

  task automatic check_reset_outs(input string name);
    check({name, "_a"}, 32'({busy_a, done_a, mem_rd_en_a, mem_rd_addr_a, m_valid_a,
                             m_data_a, m_sof_a, m_eol_a, m_eof_a}), 32'd0);
    check({name, "_b"}, 32'({busy_b, done_b, mem_rd_en_b, mem_rd_addr_b, m_valid_b,
                             m_data_b, m_sof_b, m_eol_b, m_eof_b}), 32'd0);
  endtask

  int base;
  int rd_cnt;

  initial begin
    reset_n = 1'b0; start_a = 1'b0; start_b = 1'b0; m_ready_a = 1'b1; m_ready_b = 1'b1;
    #2;
    check_reset_outs("reset_init");
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 1: padded frame, ready always high
    push_frame(0, 4, 3, 1);
    pulse_start(0);
    wait_done(0, 200, "t1_done");
    check("t1_contiguous", 32'(last_cyc_a - first_cyc_a), 32'd19);
    check("t1_queue_empty", 32'(exp_q_a.size()), 32'd0);
    repeat (3) @(posedge clk); #1;

    // 2: same frame under random backpressure
    rand_a = 1;
    push_frame(0, 4, 3, 1);
    pulse_start(0);
    wait_done(0, 400, "t2_done");
    rand_a = 0;
    @(posedge clk); #1 m_ready_a = 1'b1;
    check("t2_queue_empty", 32'(exp_q_a.size()), 32'd0);
    repeat (3) @(posedge clk); #1;

    // 3: unpadded frame
    push_frame(1, 4, 2, 0);
    pulse_start(1);
    wait_done(1, 200, "t3_done");
    check("t3_contiguous", 32'(last_cyc_b - first_cyc_b), 32'd7);
    check("t3_max_addr", 32'(max_addr_b), 32'd7);
    check("t3_queue_empty", 32'(exp_q_b.size()), 32'd0);
    repeat (3) @(posedge clk); #1;

    // 4: start while busy and in the done cycle are ignored
    push_frame(0, 4, 3, 1);
    pulse_start(0);
    repeat (5) @(posedge clk); #1;
    pulse_start(0);
    wait_done(0, 200, "t4_done");
    start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    repeat (15) @(posedge clk); #1;
    check("t4_idle", 32'(busy_a), 32'd0);
    check("t4_queue_empty", 32'(exp_q_a.size()), 32'd0);

    // 5: reset after beat 6 abandons the frame
    base = beats_a;
    push_frame(0, 4, 3, 1);
    pulse_start(0);
    for (int n = 0; n < 100 && beats_a - base < 7; n++) begin
      @(posedge clk); #1;
    end
    check("t5_reached_beat6", 32'(beats_a - base), 32'd7);
    reset_n = 1'b0;
    exp_q_a.delete();
    #1;
    check_reset_outs("t5_in_reset");
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (30) @(posedge clk); #1;
    check("t5_idle_after_reset", 32'({busy_a, m_valid_a}), 32'd0);
    push_frame(0, 4, 3, 1);
    pulse_start(0);
    wait_done(0, 200, "t5_fresh_done");
    check("t5_queue_empty", 32'(exp_q_a.size()), 32'd0);
    repeat (3) @(posedge clk); #1;

    // 6: ready low for 10 cycles at frame start
    m_ready_b = 1'b0;
    push_frame(1, 4, 2, 0);
    pulse_start(1);
    rd_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (mem_rd_en_b) rd_cnt++;
      @(posedge clk); #1;
    end
    check("t6_reads_while_stalled", 32'(rd_cnt), 32'd2);
    check("t6_head_beat0", 32'({m_valid_b, m_sof_b, m_eol_b, m_eof_b, m_data_b}),
          32'({1'b1, 1'b1, 1'b0, 1'b0, 8'd0}));
    m_ready_b = 1'b1;
    wait_done(1, 200, "t6_done");
    check("t6_queue_empty", 32'(exp_q_b.size()), 32'd0);
    repeat (3) @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected bench completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/image_stream_source.md
Name: image_stream_source

Overview:
- Raster pixel source for the Sobel datapath: reads a stored image from a synchronous-read pixel memory and emits it as a valid/ready pixel stream.
- Optionally adds zero rows above and below the image, so the downstream 3x3 window logic receives top/bottom padding without special cases.
- Sits between the frame memory (loaded from the lena_bin image) and the Sobel line-buffer/filter block.
- It is the producing end of the pixel stream interface that the filter consumes.

Parameters:
- IMAGE_WIDTH, 512, pixels per line.
- IMAGE_HEIGHT, 512, image lines stored in memory.
- PIXEL_WIDTH, 8, bits per pixel.
- PAD_ROWS, 1, zero rows emitted before line 0 and after the last line (0..2).
- ADDR_WIDTH, 18, memory address width; must satisfy 2^ADDR_WIDTH >= IMAGE_WIDTH*IMAGE_HEIGHT.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to stream one frame; ignored while busy=1.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse, cycle after the eof beat handshakes.
- mem_rd_en  out  1  memory read strobe.
- mem_rd_addr  out  ADDR_WIDTH  pixel address, row*IMAGE_WIDTH+col.
- mem_rd_data  in  PIXEL_WIDTH  read data, valid exactly 1 cycle after mem_rd_en.
- m_valid  out  1  stream beat valid.
- m_ready  in  1  downstream accept.
- m_data  out  PIXEL_WIDTH  pixel value.
- m_sof  out  1  first beat of frame.
- m_eol  out  1  last beat of a line.
- m_eof  out  1  last beat of frame.

Behaviour:
- Reset (async, reset_n=0) drives the block to IDLE. All outputs are 0: busy, done, mem_rd_en, mem_rd_addr, m_valid, m_data, m_sof, m_eol, m_eof. Counters and FIFO are cleared.
- Reset mid-frame abandons the frame; no further beats are emitted after release until a new start.
- State IDLE: start=1 loads row=0 (virtual, counting padding), col=0, addr=0, issued=0, and moves to RUN. busy=1 from the next cycle.
- State RUN issues one fetch per cycle when credit is available.
  - Credit: (fetches in flight + FIFO occupancy) < 2.
  - Virtual rows 0..PAD_ROWS-1 and the last PAD_ROWS rows are padding. They assert no mem_rd_en but still take one pipeline slot with 1-cycle latency and data 0.
  - Image rows assert mem_rd_en with mem_rd_addr. addr increments by 1 per image fetch, with no multiplier.
  - Each fetch carries tag bits {sof, eol, eof}: sof when virtual row=0 and col=0; eol when col=IMAGE_WIDTH-1; eof when it is the last col of the last virtual row.
  - col wraps to 0 at IMAGE_WIDTH-1 and row increments.
  - After the eof fetch issues, move to DRAIN.
- State DRAIN: no fetches. Stay until the eof beat handshakes (m_valid && m_ready && m_eof), then pulse done for one cycle, clear busy, and return to IDLE.
- Returning data (mem data, or 0 for padding) plus tag is written into a 2-entry FIFO. The stream outputs are driven from the FIFO head.
  - Credit rule guarantees no overflow, so there is no write-when-full case.
  - Simultaneous FIFO write and read is allowed.
- Handshake:
  - A beat transfers when m_valid && m_ready.
  - While m_valid && !m_ready, m_data and all flags hold stable.
  - m_valid never drops without a transfer.
- Throughput: with m_ready held 1, one beat per cycle after 2 cycles of initial latency (start to first m_valid).
- Total beats per frame: IMAGE_WIDTH*(IMAGE_HEIGHT+2*PAD_ROWS).
- m_sof, m_eol and m_eof may coincide only as the frame geometry dictates. With IMAGE_WIDTH=1 every beat has eol.
- start arriving in the same cycle as done is ignored; start is sampled only in IDLE.
- Reads never run past address IMAGE_WIDTH*IMAGE_HEIGHT-1.

Decomposition:
- Shared package sobel_stream_pkg holds:
  - typedef pix_t (PIXEL_WIDTH bits);
  - struct stream_flags_t {sof, eol, eof};
  - state enum {IDLE, RUN, DRAIN};
  - localparams for column and row counter widths, clog2 of width and of height plus padding.
- One sub-module, stream_skid_fifo: a 2-entry data+flags FIFO with count output, reused later by the Sobel output side.

Test Plan:
- W=4, H=3, PAD=1, memory holds addr values; start, m_ready=1 -> 20 contiguous beats.
  - Beats 0-3 and 16-19 are data 0; beats 4-15 are 0..11.
  - sof on beat 0, eol on beats 3,7,11,15,19, eof on beat 19.
  - done on the cycle after beat 19.
- Same config, m_ready pseudo-random 50% -> identical beat sequence; data and flags stable across every stall; mem_rd_en never asserted more than 2 ahead of consumption.
- PAD=0, W=4, H=2 -> 8 beats 0..7; sof at beat 0; eof at beat 7; no zero beats; mem_rd_addr max 7.
- start pulsed again while busy, and in the done cycle -> exactly one frame emitted; second start ignored.
- reset_n low for 1 cycle after beat 6 of a frame -> all outputs 0 during reset; no beats after release; a later start produces a complete fresh frame from sof.
- m_ready=0 held for 10 cycles at the start of the frame -> exactly 2 reads issued, m_valid held with beat 0, no FIFO overflow, sequence resumes correctly.
